// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master: controller (decodes IR, drives strobes); slave: datapath side.
interface multicycle_control_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 5
);
    logic [INSTR_W-1:0] instruction;
    logic               mem_ready;
    logic               zero;
    logic               irWrite;
    logic               enablePC;
    logic               branch;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrc;
    logic               regWrite;
    logic               illegal;
    logic               bus_error;
    logic [3:0]         state;

    modport master (
        input  instruction, mem_ready, zero,
        output irWrite, enablePC, branch, memRead, memWrite,
        output memToReg, ALUOp, ALUSrc, regWrite,
        output illegal, bus_error, state
    );

    modport slave (
        output instruction, mem_ready, zero,
        input  irWrite, enablePC, branch, memRead, memWrite,
        input  memToReg, ALUOp, ALUSrc, regWrite,
        input  illegal, bus_error, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// mem_ready wait-state stretching and timeout abort. Ports: clock, reset_n, bus.
module multicycle_control #(
    parameter int INSTR_W   = 32,
    parameter int ALUOP_W   = 5,
    parameter int CLASS_LSB = 29,
    parameter int LS_BIT    = 24,
    parameter int FUNCT_LSB = 24,
    parameter int ADD_OP    = 0,
    parameter int SUB_OP    = 1,
    parameter int MAX_WAIT  = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    multicycle_control_if.master  bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB_ALU = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    cls;
    logic          rdy;
    logic          is_wait;
    logic          timeout;

    logic               o_ir, o_pc, o_br, o_mrd, o_mwr, o_m2r;
    logic [ALUOP_W-1:0] o_op;
    logic               o_src, o_rw, o_ill, o_berr;

    // Only class, funct and L/S bits are decoded; the rest of IR is datapath's.
    logic unused_instr;
    assign unused_instr = ^bus.instruction;

    assign cls     = bus.instruction[CLASS_LSB +: 3];
    assign rdy     = bus.mem_ready;
    assign is_wait = (cur == S_FETCH) || (cur == S_MEM_RD) ||
                     (cur == S_MEM_WR);
    // Abort only when the last allowed cycle also lacks mem_ready.
    assign timeout = is_wait && !rdy && (cnt == CMAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_FETCH:  if (rdy) nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (cls == 3'b100): nxt = S_EXEC;
                    (cls == 3'b001): nxt = S_ADDR;
                    (cls == 3'b010): nxt = S_BRANCH;
                    default:         nxt = S_FETCH;
                endcase
            end
            S_EXEC:   nxt = S_WB_ALU;
            S_WB_ALU: nxt = S_FETCH;
            S_ADDR:   nxt = bus.instruction[LS_BIT] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (rdy) nxt = S_WB_MEM;
            S_WB_MEM: nxt = S_FETCH;
            S_MEM_WR: if (rdy) nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
        if (timeout) nxt = S_FETCH;
    end

    // A FETCH timeout re-enters FETCH, so clear on timeout as well as exit.
    always_comb begin
        cnt_nxt = '0;
        if (!timeout && nxt == cur && is_wait && !rdy)
            cnt_nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
    end

    // Held idle combinationally during reset so strobes release at once.
    always_comb begin
        o_ir   = 1'b0;
        o_pc   = 1'b0;
        o_br   = 1'b0;
        o_mrd  = 1'b1;
        o_mwr  = 1'b1;
        o_m2r  = 1'b0;
        o_op   = '0;
        o_src  = 1'b0;
        o_rw   = 1'b0;
        o_ill  = 1'b0;
        o_berr = 1'b0;
        if (reset_n) begin
            unique case (cur)
                S_FETCH: begin
                    o_mrd  = 1'b0;
                    o_ir   = rdy;
                    o_pc   = rdy;
                    o_berr = timeout;
                end
                S_DECODE: begin
                    o_ill = !((cls == 3'b100) || (cls == 3'b001) ||
                              (cls == 3'b010));
                end
                S_EXEC: begin
                    o_op = bus.instruction[FUNCT_LSB +: ALUOP_W];
                end
                S_WB_ALU: begin
                    o_rw = 1'b1;
                end
                S_ADDR: begin
                    o_src = 1'b1;
                    o_op  = ALUOP_W'(ADD_OP);
                end
                S_MEM_RD: begin
                    o_src  = 1'b1;
                    o_op   = ALUOP_W'(ADD_OP);
                    o_mrd  = 1'b0;
                    o_berr = timeout;
                end
                S_WB_MEM: begin
                    o_rw  = 1'b1;
                    o_m2r = 1'b1;
                end
                S_MEM_WR: begin
                    o_src  = 1'b1;
                    o_op   = ALUOP_W'(ADD_OP);
                    o_mwr  = 1'b0;
                    o_berr = timeout;
                end
                S_BRANCH: begin
                    o_op = ALUOP_W'(SUB_OP);
                    o_br = bus.zero;
                    o_pc = bus.zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.irWrite   = o_ir;
    assign bus.enablePC  = o_pc;
    assign bus.branch    = o_br;
    assign bus.memRead   = o_mrd;
    assign bus.memWrite  = o_mwr;
    assign bus.memToReg  = o_m2r;
    assign bus.ALUOp     = o_op;
    assign bus.ALUSrc    = o_src;
    assign bus.regWrite  = o_rw;
    assign bus.illegal   = o_ill;
    assign bus.bus_error = o_berr;
    assign bus.state     = cur;
endmodule
